// File: rtl/uart_pkg.sv
// Shared UART defaults used by the receive and transmit buffering blocks.
package uart_pkg;

  localparam int unsigned DefWidthData = 8;
  localparam int unsigned DefDepthLog2 = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers and occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    mem_q [Depth];
  logic                do_wr, do_rd;

  // A write into a full FIFO is legal only when a pop frees the head slot in the same cycle.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
              (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    count   = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: rtl/rx_fifo.sv
// Receive buffer behind the UART receiver: one capture per ready pulse, FWFT queue,
// sticky overrun flag for frames dropped while full.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = DefWidthData,
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_rx_rdy,
  input  logic [WIDTH_DATA-1:0] i_rx_data,
  output logic                  o_rx_re,
  input  logic                  i_rd,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_ovr,
  input  logic                  i_ovr_clr
);

  logic rx_re_q;
  logic ovr_q, ovr_d;
  logic capture;
  logic ovr_set;

  // Ready rising edge; the registered acknowledge masks a held ready.
  always_comb begin
    capture = i_rx_rdy && !rx_re_q;
    ovr_set = capture && o_full && !i_rd;
    ovr_d   = ovr_q;
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_re_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_re_q <= i_rx_rdy;
      ovr_q   <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH      (WIDTH_DATA),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (i_clk),
    .nrst    (i_nrst),
    .wr_en   (capture),
    .wr_data (i_rx_data),
    .rd_en   (i_rd),
    .rd_data (o_data),
    .empty   (o_empty),
    .full    (o_full),
    .count   (o_count)
  );

  assign o_rx_re = rx_re_q;
  assign o_ovr   = ovr_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: vector table for handshake/empty cases, sequences for full cases.
module tb_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_nrst;
  logic       i_rx_rdy;
  logic [7:0] i_rx_data;
  logic       o_rx_re;
  logic       i_rd;
  logic [7:0] o_data;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_ovr;
  logic       i_ovr_clr;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  rx_fifo #(
    .WIDTH_DATA (8),
    .DEPTH_LOG2 (4)
  ) dut (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_rx_rdy  (i_rx_rdy),
    .i_rx_data (i_rx_data),
    .o_rx_re   (o_rx_re),
    .i_rd      (i_rd),
    .o_data    (o_data),
    .o_empty   (o_empty),
    .o_full    (o_full),
    .o_count   (o_count),
    .o_ovr     (o_ovr),
    .i_ovr_clr (i_ovr_clr)
  );

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic       exp_re;
    logic       exp_empty;
    logic       exp_full;
    int         exp_count;
    logic [7:0] exp_data;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs away from the edge, sample 1 time unit after the active edge.
  task automatic step(input logic rdy, input logic [7:0] d, input logic rd, input logic clr);
    @(negedge i_clk);
    i_rx_rdy  = rdy;
    i_rx_data = d;
    i_rd      = rd;
    i_ovr_clr = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Test 1: one frame with ready held 5 cycles, then drop and pop.
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[2]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    // Test 5: reads on empty, including one coincident with a capture.
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h3C, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0};

    i_nrst    = 1'b0;
    i_rx_rdy  = 1'b0;
    i_rx_data = 8'h00;
    i_rd      = 1'b0;
    i_ovr_clr = 1'b0;
    #2;
    chk("reset_re", int'(o_rx_re), 0);
    chk("reset_empty", int'(o_empty), 1);
    chk("reset_full", int'(o_full), 0);
    chk("reset_count", int'(o_count), 0);
    chk("reset_ovr", int'(o_ovr), 0);
    chk("reset_data", int'(o_data), 0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].rdy, vecs[i].data, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d_re", i), int'(o_rx_re), int'(vecs[i].exp_re));
      chk($sformatf("vec%0d_empty", i), int'(o_empty), int'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_full", i), int'(o_full), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d_count", i), int'(o_count), vecs[i].exp_count);
      chk($sformatf("vec%0d_ovr", i), int'(o_ovr), int'(vecs[i].exp_ovr));
      if (!vecs[i].exp_empty)
        chk($sformatf("vec%0d_data", i), int'(o_data), int'(vecs[i].exp_data));
    end

    // Test 2: fill to 16 entries.
    for (int i = 0; i < 16; i++) begin
      frame(8'(i));
      if (i == 14) chk("fill15_full", int'(o_full), 0);
    end
    chk("fill16_full", int'(o_full), 1);
    chk("fill16_count", int'(o_count), 16);
    chk("fill16_head", int'(o_data), 8'h00);

    // Test 3: overrun while full, set wins over clear, then clear.
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovr_set", int'(o_ovr), 1);
    chk("ovr_count", int'(o_count), 16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovr_set_prio", int'(o_ovr), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr", int'(o_ovr), 0);
    chk("ovr_head", int'(o_data), 8'h00);

    // Test 4: capture coincident with pop while full.
    step(1'b1, 8'h10, 1'b1, 1'b0);
    chk("wr_rd_full_ovr", int'(o_ovr), 0);
    chk("wr_rd_full_count", int'(o_count), 16);
    chk("wr_rd_full_full", int'(o_full), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("pop%0d_data", i), int'(o_data), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", int'(o_empty), 1);
    chk("drain_count", int'(o_count), 0);
    chk("drain_full", int'(o_full), 0);

    // Test 6: reset mid-burst with count 7 and overrun pending.
    for (int i = 0; i < 16; i++) frame(8'(8'h20 + i));
    frame(8'hEE);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("pre_rst_count", int'(o_count), 7);
    chk("pre_rst_ovr", int'(o_ovr), 1);
    chk("pre_rst_re", int'(o_rx_re), 1);
    #1;
    i_nrst = 1'b0;
    #1;
    chk("mid_rst_re", int'(o_rx_re), 0);
    chk("mid_rst_empty", int'(o_empty), 1);
    chk("mid_rst_full", int'(o_full), 0);
    chk("mid_rst_count", int'(o_count), 0);
    chk("mid_rst_ovr", int'(o_ovr), 0);
    chk("mid_rst_data", int'(o_data), 0);
    @(negedge i_clk);
    i_rx_rdy = 1'b0;
    i_nrst   = 1'b1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_count", int'(o_count), 1);
    chk("post_rst_data", int'(o_data), 8'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_pop_empty", int'(o_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
